truth_table_checker: RTL and testbench

Sequential exhaustive-equivalence checker for small combinational gate networks. On `start` it sweeps every input combination, drives each onto two implementations under comparison, samples both responses after a settle interval, and records both truth tables, a mismatch count and the first failing vector. It replaces hand-written `#1` stimulus sequences in the gate-level experiments with a clocked, self-checking sweep usable in simulation or on a board.

---
 rtl/tt_pkg.sv | 19 +
 rtl/tt_vec_seq.sv | 48 ++++
 rtl/truth_table_checker.sv | 100 ++++++++++
 tb/tb_truth_table_checker.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// tt_pkg: shared definitions for the truth-table equivalence checker.
//   tt_state_e          - sweep FSM states
//   N_IN_DEFAULT        - default number of inputs swept (legal 1..6)
//   SETTLE_CYC_DEFAULT  - default hold cycles per vector (legal 1..15)
//   SETTLE_W            - settle counter width, wide enough for 15 cycles
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    localparam int N_IN_DEFAULT       = 2;
    localparam int SETTLE_CYC_DEFAULT = 1;
    localparam int SETTLE_W           = 4;

endpackage

// File: rtl/tt_vec_seq.sv
// tt_vec_seq: stimulus vector counter and per-vector settle timer.
//   clk, rst   - clock, synchronous active-high reset
//   launch     - new sweep accepted: vec and settle counter to 0
//   settling   - FSM is in SETTLE: advance the settle counter
//   advance    - FSM is in SAMPLE and more vectors remain: next vec
//   vec        - current stimulus vector
//   sample_en  - final SETTLE cycle; the FSM moves to SAMPLE on the next edge
//   last_vec   - vec is the all-ones (final) vector
module tt_vec_seq import tt_pkg::*; #(
    parameter int N_IN       = N_IN_DEFAULT,
    parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            launch,
    input  logic            settling,
    input  logic            advance,
    output logic [N_IN-1:0] vec,
    output logic            sample_en,
    output logic            last_vec
);

    logic [SETTLE_W-1:0] settle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            vec        <= '0;
            settle_cnt <= '0;
        end else if (launch) begin
            vec        <= '0;
            settle_cnt <= '0;
        end else if (advance) begin
            vec        <= vec + N_IN'(1);
            settle_cnt <= '0;
        end else if (settling) begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
        end
    end

    // The counter is 0 on the first SETTLE cycle, so the last of the
    // SETTLE_CYC hold cycles is the one where it reads SETTLE_CYC-1.
    assign sample_en = settling && (settle_cnt == SETTLE_W'(SETTLE_CYC - 1));

    // vec stops at all-ones: the FSM goes to DONE instead of advancing,
    // so it never wraps within a sweep.
    assign last_vec  = (vec == {N_IN{1'b1}});

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every N_IN-bit input vector over two
// combinational implementations and compares their responses.
//   clk, rst        - clock, synchronous active-high reset
//   start           - request a sweep (ignored while busy)
//   vec             - stimulus to both implementations (MSB = input a)
//   resp_a, resp_b  - responses of implementations A and B
//   busy            - sweep in progress (SETTLE or SAMPLE)
//   done            - results valid (level)
//   pass            - done with zero mismatches
//   mismatch_cnt    - number of vectors where resp_a != resp_b
//   table_a/table_b - bit i = response sampled at vec == i
//   first_fail      - lowest mismatching vector
//   first_fail_vld  - first_fail is meaningful
module truth_table_checker import tt_pkg::*; #(
    parameter int N_IN       = N_IN_DEFAULT,
    parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      vec,
    input  logic                 resp_a,
    input  logic                 resp_b,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [2**N_IN-1:0]   table_a,
    output logic [2**N_IN-1:0]   table_b,
    output logic [N_IN-1:0]      first_fail,
    output logic                 first_fail_vld
);

    tt_state_e state, state_nxt;
    logic      launch, sampling, advance, sample_en, last_vec, differ;

    assign launch   = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    assign sampling = (state == ST_SAMPLE);
    assign advance  = sampling && !last_vec;
    assign differ   = resp_a ^ resp_b;

    tt_vec_seq #(
        .N_IN       (N_IN),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_vec_seq (
        .clk       (clk),
        .rst       (rst),
        .launch    (launch),
        .settling  (state == ST_SETTLE),
        .advance   (advance),
        .vec       (vec),
        .sample_en (sample_en),
        .last_vec  (last_vec)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start)     state_nxt = ST_SETTLE;
            ST_SETTLE:        if (sample_en) state_nxt = ST_SAMPLE;
            ST_SAMPLE:        state_nxt = last_vec ? ST_DONE : ST_SETTLE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Result registers. A restart clears everything so a second sweep
    // never inherits bits from the first.
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            table_a        <= '0;
            table_b        <= '0;
            mismatch_cnt   <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else if (sampling) begin
            table_a[vec] <= resp_a;
            table_b[vec] <= resp_b;
            if (differ) begin
                mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
                // vec rises monotonically, so the first mismatch seen is the lowest.
                if (!first_fail_vld) begin
                    first_fail     <= vec;
                    first_fail_vld <= 1'b1;
                end
            end
        end
    end

    // Status decoded from the state register: the final sample edge moves
    // to DONE and updates mismatch_cnt together, so pass is exact at once.
    assign busy = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done = (state == ST_DONE);
    assign pass = done && (mismatch_cnt == '0);

endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: three checker instances (N_IN/SETTLE_CYC of
// 2/1, 2/3 and 3/2) driven by truth-table-defined implementations.
// Expected results come from the truth tables themselves: masked tables,
// popcount of their XOR, lowest set bit, and latency 2**N*(S+1).
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_v [3];
    logic [15:0] fa [3];
    logic [15:0] fb [3];

    int n_chk  = 0;
    int n_fail = 0;

    // instance 0: N_IN=2, SETTLE_CYC=1
    logic [1:0] vec0, ff0; logic [2:0] mc0; logic [3:0] ta0, tb0;
    logic busy0, done0, pass0, ffv0, ra0, rb0;
    // instance 1: N_IN=2, SETTLE_CYC=3
    logic [1:0] vec1, ff1; logic [2:0] mc1; logic [3:0] ta1, tb1;
    logic busy1, done1, pass1, ffv1, ra1, rb1;
    // instance 2: N_IN=3, SETTLE_CYC=2
    logic [2:0] vec2, ff2; logic [3:0] mc2; logic [7:0] ta2, tb2;
    logic busy2, done2, pass2, ffv2, ra2, rb2;

    assign ra0 = fa[0][vec0]; assign rb0 = fb[0][vec0];
    assign ra1 = fa[1][vec1]; assign rb1 = fb[1][vec1];
    assign ra2 = fa[2][vec2]; assign rb2 = fb[2][vec2];

    truth_table_checker #(.N_IN(2), .SETTLE_CYC(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .vec(vec0), .resp_a(ra0), .resp_b(rb0),
        .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(mc0), .table_a(ta0),
        .table_b(tb0), .first_fail(ff0), .first_fail_vld(ffv0));
    truth_table_checker #(.N_IN(2), .SETTLE_CYC(3)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .vec(vec1), .resp_a(ra1), .resp_b(rb1),
        .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mc1), .table_a(ta1),
        .table_b(tb1), .first_fail(ff1), .first_fail_vld(ffv1));
    truth_table_checker #(.N_IN(3), .SETTLE_CYC(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .vec(vec2), .resp_a(ra2), .resp_b(rb2),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(mc2), .table_a(ta2),
        .table_b(tb2), .first_fail(ff2), .first_fail_vld(ffv2));

    // uniform views so one set of tasks serves every instance
    logic [15:0] o_vec [3], o_mc [3], o_ta [3], o_tb [3], o_ff [3];
    logic        o_busy [3], o_done [3], o_pass [3], o_ffv [3];
    assign o_vec[0] = 16'(vec0); assign o_vec[1] = 16'(vec1); assign o_vec[2] = 16'(vec2);
    assign o_mc[0]  = 16'(mc0);  assign o_mc[1]  = 16'(mc1);  assign o_mc[2]  = 16'(mc2);
    assign o_ta[0]  = 16'(ta0);  assign o_ta[1]  = 16'(ta1);  assign o_ta[2]  = 16'(ta2);
    assign o_tb[0]  = 16'(tb0);  assign o_tb[1]  = 16'(tb1);  assign o_tb[2]  = 16'(tb2);
    assign o_ff[0]  = 16'(ff0);  assign o_ff[1]  = 16'(ff1);  assign o_ff[2]  = 16'(ff2);
    assign o_busy[0] = busy0; assign o_busy[1] = busy1; assign o_busy[2] = busy2;
    assign o_done[0] = done0; assign o_done[1] = done1; assign o_done[2] = done2;
    assign o_pass[0] = pass0; assign o_pass[1] = pass1; assign o_pass[2] = pass2;
    assign o_ffv[0]  = ffv0;  assign o_ffv[1]  = ffv1;  assign o_ffv[2]  = ffv2;

    function automatic int nin(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int scyc(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
    endfunction

    localparam int G_NAND = 0, G_NEGOR = 1, G_NOR = 2, G_NEGAND = 3, G_AND = 4;

    // two-input gate truth table, index = {a,b}
    function automatic logic [15:0] gate_tt(input int g);
        logic [15:0] t;
        int a, b;
        t = '0;
        for (int i = 0; i < 4; i++) begin
            a = (i >> 1) & 1;
            b = i & 1;
            case (g)
                G_NAND:   t[i] = !(a && b);
                G_NEGOR:  t[i] = !a || !b;
                G_NOR:    t[i] = !(a || b);
                G_NEGAND: t[i] = !a && !b;
                default:  t[i] = a && b;
            endcase
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk($sformatf("d%0d %s vec", d, tag),  o_vec[d],  0);
        chk($sformatf("d%0d %s busy", d, tag), o_busy[d], 0);
        chk($sformatf("d%0d %s done", d, tag), o_done[d], 0);
        chk($sformatf("d%0d %s pass", d, tag), o_pass[d], 0);
        chk($sformatf("d%0d %s mcnt", d, tag), o_mc[d],   0);
        chk($sformatf("d%0d %s ta", d, tag),   o_ta[d],   0);
        chk($sformatf("d%0d %s tb", d, tag),   o_tb[d],   0);
        chk($sformatf("d%0d %s ff", d, tag),   o_ff[d],   0);
        chk($sformatf("d%0d %s ffv", d, tag),  o_ffv[d],  0);
    endtask

    // Run one sweep on instance d. If poke_at >= 0, start is asserted
    // again so that it is sampled poke_at+1 edges into the sweep.
    task automatic sweep(input int d, input int poke_at);
        int nv, lat, mism, ff, n, gaps;
        logic [15:0] m, x;
        nv   = 1 << nin(d);
        lat  = nv * (scyc(d) + 1);
        m    = 16'((32'd1 << nv) - 1);
        x    = (fa[d] ^ fb[d]) & m;
        mism = $countones(x);
        ff   = 0;
        for (int i = nv - 1; i >= 0; i--) if (x[i]) ff = i;

        @(negedge clk); start_v[d] = 1'b1;
        @(posedge clk); #1; start_v[d] = 1'b0;
        chk($sformatf("d%0d start busy", d), o_busy[d], 1);
        chk($sformatf("d%0d start vec", d),  o_vec[d],  0);
        chk($sformatf("d%0d start done", d), o_done[d], 0);
        chk($sformatf("d%0d start clr", d),
            {o_ta[d], o_tb[d], o_mc[d], 15'd0, o_ffv[d]}, 0);

        n = 0; gaps = 0;
        while (!o_done[d] && n < lat + 20) begin
            if (n == poke_at) start_v[d] = 1'b1;
            @(posedge clk); #1;
            start_v[d] = 1'b0;
            n++;
            if (!o_done[d] && !o_busy[d]) gaps++;
        end
        chk($sformatf("d%0d latency", d),   n,         lat);
        chk($sformatf("d%0d busy gaps", d), gaps,      0);
        chk($sformatf("d%0d end busy", d),  o_busy[d], 0);
        chk($sformatf("d%0d end vec", d),   o_vec[d],  nv - 1);
        chk($sformatf("d%0d table_a", d),   o_ta[d],   fa[d] & m);
        chk($sformatf("d%0d table_b", d),   o_tb[d],   fb[d] & m);
        chk($sformatf("d%0d mcnt", d),      o_mc[d],   mism);
        chk($sformatf("d%0d pass", d),      o_pass[d], mism == 0);
        chk($sformatf("d%0d ffv", d),       o_ffv[d],  mism != 0);
        chk($sformatf("d%0d ff", d),        o_ff[d],   ff);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0; fa[d] = '0; fb[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk_zero(d, "reset");
        @(negedge clk); rst = 1'b0;

        // NAND vs negative-OR: equivalent
        fa[0] = gate_tt(G_NAND); fb[0] = gate_tt(G_NEGOR);
        sweep(0, -1);
        chk("nand/negor ta const", o_ta[0], 4'b0111);
        chk("nand/negor tb const", o_tb[0], 4'b0111);

        // NOR vs negative-AND: equivalent
        fa[0] = gate_tt(G_NOR); fb[0] = gate_tt(G_NEGAND);
        sweep(0, -1);
        chk("nor/negand ta const", o_ta[0], 4'b0001);

        // NAND vs NOR: two mismatches, first at vector 1
        fa[0] = gate_tt(G_NAND); fb[0] = gate_tt(G_NOR);
        sweep(0, -1);
        chk("nand/nor mcnt const", o_mc[0], 2);
        chk("nand/nor ff const",   o_ff[0], 1);

        // NAND vs AND, longer settle: 16 cycles, every vector differs
        fa[1] = gate_tt(G_NAND); fb[1] = gate_tt(G_AND);
        sweep(1, -1);
        chk("nand/and mcnt const", o_mc[1], 4);
        chk("nand/and ff const",   o_ff[1], 0);

        // reset three cycles into a sweep abandons it
        @(negedge clk); start_v[0] = 1'b1;
        @(posedge clk); #1; start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_zero(0, "midrst");
        @(negedge clk); rst = 1'b0;
        sweep(0, -1);

        // reset and start together: reset wins
        @(negedge clk); rst = 1'b1; start_v[0] = 1'b1;
        @(posedge clk); #1;
        chk_zero(0, "rst+start");
        @(negedge clk); rst = 1'b0; start_v[0] = 1'b0;

        // start while busy is ignored; then restart from DONE
        sweep(0, 3);
        sweep(0, -1);

        // every vector mismatching: count reaches 2**N_IN
        fa[2] = 16'h00a5; fb[2] = ~fa[2];
        sweep(2, -1);
        chk("all-mismatch mcnt", o_mc[2], 8);

        // randomized truth tables
        for (int it = 0; it < 16; it++) begin
            int d;
            d = (it % 2 == 0) ? 2 : 0;
            fa[d] = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       fb[d] = fa[d];
                1:       fb[d] = ~fa[d];
                default: fb[d] = 16'($urandom);
            endcase
            sweep(d, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
